// File: rtl/clk_div_frac_mch.sv
// Multi-channel fractional clock divider: per-channel integer+fraction half-period counter,
// double-buffered config applied at period end, optional cascade from the previous channel's tick.
module clk_div_frac_mch #(
  parameter int unsigned CChCnt  = 4,
  parameter int unsigned CChIdxW = 2,
  parameter int unsigned CIntW   = 8,
  parameter int unsigned CFraW   = 8
) (
  input  logic                     AClkH,
  input  logic                     AResetHN,
  input  logic                     AClkHEn,
  input  logic                     AWrEn,
  input  logic [CChIdxW-1:0]       AWrCh,
  input  logic [CIntW+CFraW+1:0]   AWrData,
  input  logic                     ASync,
  output logic [CChCnt-1:0]        AClkOut,
  output logic [CChCnt-1:0]        ATick,
  output logic [CChCnt-1:0]        AActive
);

  localparam int unsigned CCfgW = CIntW + CFraW + 2;

  for (genvar gi = 0; gi < CChCnt; gi++) begin : g_ch
    logic [CCfgW-1:0] r_shadow;
    logic [CCfgW-1:0] r_cfg;
    logic [CIntW-1:0] r_fcnt;
    logic [CFraW-1:0] r_facc;
    logic             r_clk;
    logic             r_tick;
    logic             r_active;

    logic             w_wr;
    logic             w_step;
    logic             w_sh_ok;
    logic [CIntW-1:0] w_sh_int;
    logic [CIntW-1:0] w_cfg_int;
    logic [CFraW-1:0] w_cfg_fra;
    logic [CFraW:0]   w_sum;
    logic [CIntW-1:0] w_fcnt_nx;

    assign w_wr      = AWrEn && (AWrCh == CChIdxW'(gi));
    assign w_sh_int  = r_shadow[CFraW +: CIntW];
    assign w_sh_ok   = r_shadow[CCfgW-2] && (w_sh_int != '0);
    assign w_cfg_int = r_cfg[CFraW +: CIntW];
    assign w_cfg_fra = r_cfg[CFraW-1:0];
    assign w_sum     = {1'b0, r_facc} + {1'b0, w_cfg_fra};
    assign w_fcnt_nx = w_cfg_int - CIntW'(1) + CIntW'(w_sum[CFraW]);

    if (gi == 0) begin : g_step0
      assign w_step = AClkHEn;
    end else begin : g_stepn
      logic w_cas;
      // A stopped channel will load from the shadow, so its cascade bit decides the step source.
      assign w_cas  = r_active ? r_cfg[CCfgW-1] : r_shadow[CCfgW-1];
      assign w_step = w_cas ? ATick[gi-1] : AClkHEn;
    end

    always_ff @(posedge AClkH or negedge AResetHN) begin
      if (!AResetHN) begin
        r_shadow <= '0;
        r_cfg    <= '0;
        r_fcnt   <= '0;
        r_facc   <= '0;
        r_clk    <= 1'b0;
        r_tick   <= 1'b0;
        r_active <= 1'b0;
      end else begin
        if (w_wr) begin
          r_shadow <= AWrData;
        end
        r_tick <= 1'b0;
        if (ASync) begin
          r_clk <= 1'b0;
          if (w_sh_ok) begin
            r_cfg    <= r_shadow;
            r_fcnt   <= w_sh_int - CIntW'(1);
            r_facc   <= '0;
            r_active <= 1'b1;
          end else begin
            r_active <= 1'b0;
          end
        end else if (w_step) begin
          if (!r_active) begin
            if (w_sh_ok) begin
              r_cfg    <= r_shadow;
              r_fcnt   <= w_sh_int - CIntW'(1);
              r_facc   <= '0;
              r_clk    <= 1'b0;
              r_active <= 1'b1;
            end
          end else if (r_fcnt != '0) begin
            r_fcnt <= r_fcnt - CIntW'(1);
          end else if (r_clk && (r_shadow != r_cfg)) begin
            // Falling edge with a pending new config: swap it in and restart the accumulator.
            r_tick   <= 1'b1;
            r_clk    <= 1'b0;
            r_cfg    <= r_shadow;
            r_fcnt   <= w_sh_int - CIntW'(1);
            r_facc   <= '0;
            r_active <= w_sh_ok;
          end else begin
            // Unchanged config keeps the accumulator running so the fraction is realised.
            r_tick <= r_clk;
            r_clk  <= ~r_clk;
            r_facc <= w_sum[CFraW-1:0];
            r_fcnt <= w_fcnt_nx;
          end
        end
      end
    end

    assign AClkOut[gi] = r_clk;
    assign ATick[gi]   = r_tick;
    assign AActive[gi] = r_active;
  end

endmodule

// File: tb/tb_clk_div_frac_mch.sv
// Randomised bench for clk_div_frac_mch (3 channels) against a steps-remaining reference model
// whose fractional carries come from the closed form floor(a*Fra/256) - floor((a-1)*Fra/256).
module tb_clk_div_frac_mch;

  localparam int NCh = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [17:0] wr_data = '0;
  logic        sync = 1'b0;
  logic [NCh-1:0] clk_out, tick, active;

  int n_checks = 0;
  int n_fails  = 0;

  // Model state: config words, level, pending tick, steps left in the current half, fraction adds.
  bit [17:0] m_sh[NCh];
  bit [17:0] m_cfg[NCh];
  bit        m_act[NCh];
  bit        m_lvl[NCh];
  bit        m_tck[NCh];
  int        m_left[NCh];
  longint    m_adds[NCh];

  clk_div_frac_mch #(
    .CChCnt (NCh),
    .CChIdxW(2),
    .CIntW  (8),
    .CFraW  (8)
  ) u_dut (
    .AClkH   (clk),
    .AResetHN(rst_n),
    .AClkHEn (en),
    .AWrEn   (wr_en),
    .AWrCh   (wr_ch),
    .AWrData (wr_data),
    .ASync   (sync),
    .AClkOut (clk_out),
    .ATick   (tick),
    .AActive (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [17:0] cfgw(input bit cas, input bit ena, input int i, input int f);
    bit [7:0] iv;
    bit [7:0] fv;
    iv = 8'(i);
    fv = 8'(f);
    return {cas, ena, iv, fv};
  endfunction

  function automatic int carry(input longint a, input int f);
    return int'(((a * f) >> 8) - (((a - 1) * f) >> 8));
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCh; c++) begin
      m_sh[c] = '0; m_cfg[c] = '0; m_act[c] = 0; m_lvl[c] = 0; m_tck[c] = 0;
      m_left[c] = 0; m_adds[c] = 0;
    end
  endtask

  task automatic model_load(input int c);
    m_cfg[c]  = m_sh[c];
    m_left[c] = int'(m_sh[c][15:8]);
    m_adds[c] = 0;
    m_lvl[c]  = 0;
    m_act[c]  = 1;
  endtask

  // One AClkH edge using the pre-edge inputs and model state.
  task automatic model_update();
    bit pt[NCh];
    bit ok, cas, stp;
    for (int c = 0; c < NCh; c++) pt[c] = m_tck[c];
    for (int c = 0; c < NCh; c++) begin
      m_tck[c] = 0;
      ok = m_sh[c][16] && (m_sh[c][15:8] != 0);
      if (sync) begin
        if (ok) model_load(c);
        else begin
          m_act[c] = 0;
          m_lvl[c] = 0;
        end
      end else begin
        cas = m_act[c] ? m_cfg[c][17] : m_sh[c][17];
        stp = (c > 0 && cas) ? pt[c-1] : en;
        if (stp) begin
          if (!m_act[c]) begin
            if (ok) model_load(c);
          end else begin
            m_left[c]--;
            if (m_left[c] == 0) begin
              if (m_lvl[c] && m_sh[c] != m_cfg[c]) begin
                m_tck[c]  = 1;
                m_lvl[c]  = 0;
                m_cfg[c]  = m_sh[c];
                m_adds[c] = 0;
                m_act[c]  = ok;
                m_left[c] = int'(m_sh[c][15:8]);
              end else begin
                m_tck[c] = m_lvl[c];
                m_lvl[c] = !m_lvl[c];
                m_adds[c]++;
                m_left[c] = int'(m_cfg[c][15:8]) + carry(m_adds[c], int'(m_cfg[c][7:0]));
              end
            end
          end
        end
      end
    end
    if (wr_en && wr_ch < NCh) m_sh[wr_ch] = wr_data;
  endtask

  // Drive inputs, take one posedge, then compare all outputs at the following negedge.
  task automatic cyc(input bit e, input bit w, input bit [1:0] ch, input bit [17:0] d,
                     input bit s);
    en = e; wr_en = w; wr_ch = ch; wr_data = d; sync = s;
    @(posedge clk);
    model_update();
    @(negedge clk);
    for (int c = 0; c < NCh; c++) begin
      check($sformatf("clk_out[%0d]", c), 32'(clk_out[c]), 32'(m_lvl[c]));
      check($sformatf("tick[%0d]", c), 32'(tick[c]), 32'(m_tck[c]));
      check($sformatf("active[%0d]", c), 32'(active[c]), 32'(m_act[c]));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 2'd0, '0, 0);
  endtask

  task automatic wr(input bit [1:0] ch, input bit [17:0] d);
    cyc(1, 1, ch, d, 0);
  endtask

  task automatic wait_tick(input int ch, output int cycles);
    cycles = 0;
    do begin
      idle(1);
      cycles++;
    end while (!tick[ch] && cycles < 100);
    check($sformatf("tick%0d_seen", ch), 32'(tick[ch]), 32'd1);
  endtask

  initial begin
    int last, nt, t;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // ch0 Int=3: period of 6, one tick per period.
    wr(2'd0, cfgw(0, 1, 3, 0));
    idle(1);
    check("ch0_loaded", 32'(active[0]), 32'd1);
    last = -1;
    nt = 0;
    for (int i = 0; i < 40; i++) begin
      idle(1);
      if (tick[0]) begin
        if (last >= 0) check("ch0_period", 32'(i - last), 32'd6);
        last = i;
        nt++;
      end
    end
    check("ch0_tick_count", 32'(nt >= 6), 32'd1);

    // ch1 fractional, then cascaded on ch0.
    wr(2'd1, cfgw(0, 1, 2, 8'h80));
    idle(40);
    wr(2'd1, cfgw(1, 1, 1, 0));
    idle(60);

    // Rewrite ch0 to Int=5 in its high phase: current period completes, next one lasts 10.
    t = 0;
    while (!clk_out[0] && t < 20) begin
      idle(1);
      t++;
    end
    check("ch0_high_seen", 32'(clk_out[0]), 32'd1);
    wr(2'd0, cfgw(0, 1, 5, 0));
    wait_tick(0, t);
    wait_tick(0, t);
    check("ch0_new_period", 32'(t), 32'd10);

    // Disable ch0: stops low after its current period.
    wr(2'd0, cfgw(0, 0, 5, 0));
    t = 0;
    while (active[0] && t < 30) begin
      idle(1);
      t++;
    end
    check("ch0_stopped", 32'(active[0]), 32'd0);
    check("ch0_stopped_low", 32'(clk_out[0]), 32'd0);
    idle(10);

    // Sync with a concurrent write to ch2 that must only reach the shadow.
    wr(2'd0, cfgw(0, 1, 3, 0));
    wr(2'd2, cfgw(0, 1, 4, 8'h40));
    idle(7);
    cyc(1, 1, 2'd2, cfgw(0, 1, 6, 0), 1);
    check("sync_clk0", 32'(clk_out[0]), 32'd0);
    check("sync_clk2", 32'(clk_out[2]), 32'd0);
    check("sync_act0", 32'(active[0]), 32'd1);
    check("sync_act2", 32'(active[2]), 32'd1);
    idle(40);

    // Out-of-range channel write is ignored.
    wr(2'd3, cfgw(0, 0, 0, 0));
    idle(20);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)),
          cfgw($urandom_range(0, 1) == 1, $urandom_range(0, 7) != 0, $urandom_range(0, 5),
               $urandom_range(0, 255)),
          $urandom_range(0, 299) == 0);
    end

    // Asynchronous reset in the middle of a period.
    wr(2'd0, cfgw(0, 1, 3, 0));
    idle(5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_clk_out", 32'(clk_out), 32'd0);
    check("arst_tick", 32'(tick), 32'd0);
    check("arst_active", 32'(active), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
